// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer: NUM_CH up/down counters sharing one prescaler, each with
// auto-reload, compare match, W1C status and a maskable level interrupt.
module apb_timer_mc #(
   parameter int CNT_WIDTH = 8,
   parameter int NUM_CH    = 2
) (
   input  logic                 pclk,
   input  logic                 preset,
   input  logic                 psel,
   input  logic                 penable,
   input  logic                 pwrite,
   input  logic [7:0]           paddr,
   input  logic [CNT_WIDTH-1:0] pwdata,
   output logic [CNT_WIDTH-1:0] prdata,
   output logic                 pready,
   output logic                 pslverr,
   output logic [NUM_CH-1:0]    irq
);

   localparam logic [2:0] OFF_TDR  = 3'd0;
   localparam logic [2:0] OFF_TCR  = 3'd1;
   localparam logic [2:0] OFF_TSR  = 3'd2;
   localparam logic [2:0] OFF_TCMP = 3'd3;
   localparam logic [2:0] OFF_TCNT = 3'd4;
   localparam logic [4:0] LAST_CH  = 5'(NUM_CH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONES = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic [3:0]           div_q;
   logic [CNT_WIDTH-1:0] tdr_q  [NUM_CH];
   logic [CNT_WIDTH-1:0] tcmp_q [NUM_CH];
   logic [CNT_WIDTH-1:0] cnt_q  [NUM_CH];
   logic [CNT_WIDTH-1:0] cnt_d  [NUM_CH];
   logic [7:0]           tcr_q  [NUM_CH];
   logic [2:0]           tsr_q  [NUM_CH];
   logic [2:0]           tsr_d  [NUM_CH];
   logic [2:0]           tsr_set[NUM_CH];
   logic [2:0]           tsr_clr[NUM_CH];
   logic [NUM_CH-1:0]    tick;
   logic [CNT_WIDTH-1:0] rd_val;

   logic [4:0] sel_ch;
   logic [2:0] sel_off;
   logic       acc_err;
   logic       wr_en;

   assign sel_ch  = paddr[7:3];
   assign sel_off = paddr[2:0];
   // TCNT is read-only, so a write to it is an error just like an unmapped offset.
   assign acc_err = (sel_off > OFF_TCNT) || (sel_ch > LAST_CH) ||
                    (pwrite && (sel_off == OFF_TCNT));
   assign wr_en   = psel && penable && pwrite && !acc_err;
   assign pslverr = psel && penable && acc_err;
   assign pready  = 1'b1;

   always_comb begin
      rd_val = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (sel_ch == 5'(c)) begin
            case (sel_off)
               OFF_TDR:  rd_val = tdr_q[c];
               OFF_TCR:  rd_val = CNT_WIDTH'(tcr_q[c]);
               OFF_TSR:  rd_val = CNT_WIDTH'(tsr_q[c]);
               OFF_TCMP: rd_val = tcmp_q[c];
               OFF_TCNT: rd_val = cnt_q[c];
               default:  rd_val = '0;
            endcase
         end
      end
      prdata = (psel && !pwrite && !acc_err) ? rd_val : '0;
   end

   always_comb begin
      tick = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         case (tcr_q[c][1:0])
            2'b00:   tick[c] = div_q[0];
            2'b01:   tick[c] = &div_q[1:0];
            2'b10:   tick[c] = &div_q[2:0];
            default: tick[c] = &div_q;
         endcase
         cnt_d[c]   = cnt_q[c];
         tsr_set[c] = 3'b000;
         if (tcr_q[c][7]) begin
            cnt_d[c] = tdr_q[c];
         end else if (tcr_q[c][4] && tick[c]) begin
            if (tcr_q[c][5]) begin
               if (cnt_q[c] == '0) begin
                  cnt_d[c]      = tcr_q[c][3] ? tdr_q[c] : CNT_ONES;
                  tsr_set[c][1] = 1'b1;
               end else begin
                  cnt_d[c] = cnt_q[c] - CNT_ONE;
               end
            end else begin
               if (cnt_q[c] == CNT_ONES) begin
                  cnt_d[c]      = tcr_q[c][3] ? tdr_q[c] : '0;
                  tsr_set[c][0] = 1'b1;
               end else begin
                  cnt_d[c] = cnt_q[c] + CNT_ONE;
               end
            end
            if (cnt_d[c] == tcmp_q[c]) tsr_set[c][2] = 1'b1;
         end
         tsr_clr[c] = (wr_en && (sel_ch == 5'(c)) && (sel_off == OFF_TSR)) ? pwdata[2:0] : 3'b000;
         // Hardware set takes priority over a simultaneous software clear.
         tsr_d[c] = (tsr_q[c] & ~tsr_clr[c]) | tsr_set[c];
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         div_q <= '0;
         irq   <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            tdr_q[c]  <= '0;
            tcmp_q[c] <= '0;
            cnt_q[c]  <= '0;
            tcr_q[c]  <= '0;
            tsr_q[c]  <= '0;
         end
      end else begin
         div_q <= div_q + 4'd1;
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c] <= cnt_d[c];
            tsr_q[c] <= tsr_d[c];
            irq[c]   <= tcr_q[c][6] && (tsr_q[c] != 3'b000);
            if (wr_en && (sel_ch == 5'(c))) begin
               case (sel_off)
                  OFF_TDR:  tdr_q[c]  <= pwdata;
                  OFF_TCR:  tcr_q[c]  <= pwdata[7:0] & 8'hFB;
                  OFF_TCMP: tcmp_q[c] <= pwdata;
                  default:  ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_timer_mc.sv
// Self-checking bench for apb_timer_mc: directed scenarios with literal expectations
// plus randomized APB traffic compared every cycle against a behavioural model.
module tb_apb_timer_mc;

   localparam int W    = 8;
   localparam int NCH  = 2;
   localparam int MAXV = (1 << W) - 1;

   logic           pclk;
   logic           preset;
   logic           psel;
   logic           penable;
   logic           pwrite;
   logic [7:0]     paddr;
   logic [W-1:0]   pwdata;
   logic [W-1:0]   prdata;
   logic           pready;
   logic           pslverr;
   logic [NCH-1:0] irq;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 0;

   logic [W-1:0] exp_q[$];

   apb_timer_mc #(.CNT_WIDTH(W), .NUM_CH(NCH)) dut (
      .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .irq(irq)
   );

   // ---------------- clock / reset ----------------
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic idle(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0]   m_tdr [NCH];
   logic [W-1:0]   m_tcmp[NCH];
   logic [W-1:0]   m_cnt [NCH];
   logic [7:0]     m_tcr [NCH];
   logic [2:0]     m_tsr [NCH];
   logic [NCH-1:0] m_irq;
   int             m_pre;
   int             edge_n;
   int             period, nc, wch, woff;
   bit             tick, wr_ok;
   logic [2:0]     setf, clrf;

   function automatic bit m_err(input logic [7:0] a, input logic wr);
      int ch;
      int off;
      ch  = int'(a) / 8;
      off = int'(a) % 8;
      return (off > 4) || (ch >= NCH) || (wr && off == 4);
   endfunction

   function automatic logic [W-1:0] m_read(input logic [7:0] a);
      int ch;
      int off;
      ch  = int'(a) / 8;
      off = int'(a) % 8;
      if (m_err(a, 1'b0)) return '0;
      case (off)
         0:       return m_tdr[ch];
         1:       return W'(m_tcr[ch]);
         2:       return W'(m_tsr[ch]);
         3:       return m_tcmp[ch];
         default: return m_cnt[ch];
      endcase
   endfunction

   always @(posedge pclk or posedge preset) begin
      if (preset) begin
         for (int c = 0; c < NCH; c++) begin
            m_tdr[c] = '0; m_tcmp[c] = '0; m_cnt[c] = '0; m_tcr[c] = '0; m_tsr[c] = '0;
         end
         m_irq  = '0;
         m_pre  = 0;
         edge_n = 0;
      end else begin
         wr_ok = psel && penable && pwrite && !m_err(paddr, 1'b1);
         wch   = int'(paddr) / 8;
         woff  = int'(paddr) % 8;
         for (int c = 0; c < NCH; c++) begin
            period = 2 << m_tcr[c][1:0];
            tick   = (m_pre % period) == (period - 1);
            nc     = int'(m_cnt[c]);
            setf   = 3'b000;
            clrf   = 3'b000;
            if (m_tcr[c][7]) begin
               nc = int'(m_tdr[c]);
            end else if (m_tcr[c][4] && tick) begin
               if (m_tcr[c][5]) begin
                  if (nc == 0) begin
                     nc = m_tcr[c][3] ? int'(m_tdr[c]) : MAXV;
                     setf[1] = 1'b1;
                  end else nc = nc - 1;
               end else begin
                  if (nc == MAXV) begin
                     nc = m_tcr[c][3] ? int'(m_tdr[c]) : 0;
                     setf[0] = 1'b1;
                  end else nc = nc + 1;
               end
               if (nc == int'(m_tcmp[c])) setf[2] = 1'b1;
            end
            m_irq[c] = m_tcr[c][6] && (m_tsr[c] != 3'b000);
            if (wr_ok && wch == c) begin
               case (woff)
                  0: m_tdr[c]  = pwdata;
                  1: m_tcr[c]  = pwdata[7:0] & 8'hFB;
                  2: clrf      = pwdata[2:0];
                  3: m_tcmp[c] = pwdata;
                  default: ;
               endcase
            end
            m_tsr[c] = (m_tsr[c] & ~clrf) | setf;
            m_cnt[c] = W'(nc);
         end
         m_pre  = (m_pre + 1) % 16;
         edge_n = edge_n + 1;
      end
   end

   // Compare process: outputs are sampled on the falling edge, inputs change just after rising.
   always @(negedge pclk) begin
      if (cmp_on) begin
         check("irq", irq, m_irq);
         check("pslverr", pslverr, psel && penable && m_err(paddr, pwrite));
         check("prdata", prdata, (psel && !pwrite) ? m_read(paddr) : '0);
         check("pready", pready, 1'b1);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic apb_write(input logic [7:0] a, input logic [W-1:0] d, output logic err);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(posedge pclk); #1 penable = 1'b1;
      @(negedge pclk); err = pslverr;
      @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [W-1:0] d, output logic err);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(posedge pclk); #1 penable = 1'b1;
      @(negedge pclk); d = prdata; err = pslverr;
      @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [W-1:0] d);
      logic e;
      apb_write(a, d, e);
      check("wr_pslverr", e, 1'b0);
   endtask

   task automatic rd(input logic [7:0] a, output logic [W-1:0] d);
      logic e;
      apb_read(a, d, e);
      check("rd_pslverr", e, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   logic [W-1:0] v, v0, last;
   logic [W-1:0] obs[5];
   int           obs_t[5];
   int           n_seen;
   logic         e;
   bit           found;

   initial begin
      preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      idle(3);
      cmp_on = 1'b1;
      preset = 1'b0;

      // Reset mid-count with an interrupt pending
      wr(8'h00, 8'hF0);
      wr(8'h01, 8'h80);
      wr(8'h01, 8'h50);
      idle(40);
      check("t1_irq_before_rst", irq[0], 1'b1);
      preset = 1'b1;
      idle(2);
      check("t1_irq_in_rst", irq, 2'b00);
      check("t1_pslverr_in_rst", pslverr, 1'b0);
      preset = 1'b0;
      for (int c = 0; c < NCH; c++)
         for (int o = 0; o < 5; o++) begin
            rd(8'(c * 8 + o), v);
            check("t1_reg_zero", v, 8'h00);
         end
      idle(20);
      rd(8'h04, v);
      check("t1_cnt_held", v, 8'h00);

      // Load and count at /2
      wr(8'h00, 8'h13);
      wr(8'h01, 8'h80);
      rd(8'h04, v);
      check("t2_loaded", v, 8'h13);
      wr(8'h01, 8'h10);
      idle(3);
      rd(8'h04, v);
      check("t2_after4", v, 8'h15);

      // Overflow, irq latency, W1C
      wr(8'h03, 8'h80);
      wr(8'h00, 8'hFE);
      wr(8'h01, 8'h80);
      wr(8'h01, 8'h50);
      idle(3);
      rd(8'h04, v);
      check("t3_wrapped", v, 8'h00);
      rd(8'h02, v);
      check("t3_ovf", v, 8'h01);
      check("t3_irq_set", irq[0], 1'b1);
      wr(8'h02, 8'h01);
      check("t3_irq_lag", irq[0], 1'b1);
      rd(8'h02, v);
      check("t3_tsr_clr", v, 8'h00);
      check("t3_irq_clr", irq[0], 1'b0);

      // Auto-reload down count on ch1 at /16
      wr(8'h0B, 8'h80);
      wr(8'h08, 8'h03);
      wr(8'h09, 8'h80);
      rd(8'h0C, v);
      obs[0] = v; obs_t[0] = edge_n; n_seen = 1; last = v;
      wr(8'h09, 8'h3B);
      for (int i = 0; i < 80 && n_seen < 5; i++) begin
         rd(8'h0C, v);
         if (v !== last) begin
            obs[n_seen] = v; obs_t[n_seen] = edge_n; n_seen++; last = v;
         end
      end
      check("t4_steps", n_seen, 5);
      exp_q.push_back(8'h03); exp_q.push_back(8'h02); exp_q.push_back(8'h01);
      exp_q.push_back(8'h00); exp_q.push_back(8'h03);
      for (int i = 0; i < n_seen; i++) check("t4_seq", obs[i], exp_q.pop_front());
      for (int i = 2; i < n_seen; i++) check("t4_gap", obs_t[i] - obs_t[i-1], 16);
      rd(8'h0A, v);
      check("t4_udf", v, 8'h02);
      check("t4_irq1", irq[1], 1'b0);
      rd(8'h01, v);
      check("t4_ch0_tcr", v, 8'h50);
      rd(8'h00, v);
      check("t4_ch0_tdr", v, 8'hFE);
      wr(8'h09, 8'h00);

      // Compare match, then set/clear collision
      wr(8'h01, 8'h00);
      wr(8'h00, 8'h00);
      wr(8'h03, 8'h05);
      wr(8'h01, 8'h80);
      wr(8'h02, 8'h07);
      wr(8'h01, 8'h13);
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         rd(8'h02, v);
         if (v[2]) found = 1'b1;
      end
      check("t5_cmf_seen", found, 1'b1);
      check("t5_cmf_only", v, 8'h04);
      rd(8'h04, v);
      check("t5_cnt_at_cmp", v, 8'h05);
      wr(8'h00, 8'h04);
      rd(8'h04, v);
      check("t5_tdr_no_effect", v, 8'h05);
      wr(8'h01, 8'h80);
      wr(8'h02, 8'h04);
      rd(8'h02, v);
      check("t5_cmf_cleared", v, 8'h00);
      while (edge_n % 16 != 0) idle(1);
      wr(8'h01, 8'h13);
      while (edge_n % 16 != 14) idle(1);
      wr(8'h02, 8'h04);
      rd(8'h02, v);
      check("t5_set_wins", v, 8'h04);
      rd(8'h04, v);
      check("t5_cnt_5", v, 8'h05);

      // Error responses
      wr(8'h01, 8'h00);
      rd(8'h04, v0);
      apb_write(8'h04, 8'hAA, e);
      check("t6_wr_tcnt_err", e, 1'b1);
      rd(8'h04, v);
      check("t6_tcnt_same", v, v0);
      apb_read(8'h05, v, e);
      check("t6_rd_off5_err", e, 1'b1);
      check("t6_rd_off5_data", v, 8'h00);
      apb_write(8'h10, 8'hAA, e);
      check("t6_wr_ch2_err", e, 1'b1);
      rd(8'h00, v);
      check("t6_tdr0_same", v, 8'h04);
      rd(8'h08, v);
      check("t6_tdr1_same", v, 8'h03);
      apb_read(8'h10, v, e);
      check("t6_rd_ch2_err", e, 1'b1);

      // Randomized traffic against the model
      for (int i = 0; i < 700; i++) begin
         int r, ch, off;
         logic [7:0] a;
         logic [W-1:0] d;
         r = $urandom_range(0, 99);
         if (r < 2) begin
            preset = 1'b1;
            idle($urandom_range(1, 2));
            preset = 1'b0;
         end else if (r < 10) begin
            idle($urandom_range(1, 6));
         end else begin
            ch  = ($urandom_range(0, 9) == 0) ? 2 : $urandom_range(0, NCH - 1);
            off = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            a   = 8'(ch * 8 + off);
            if ($urandom_range(0, 19) == 0) a = 8'($urandom_range(0, 255));
            case (off)
               1:       d = {($urandom_range(0, 3) == 0), 7'($urandom_range(0, 127))};
               0, 3:    d = $urandom_range(0, 1) ? W'($urandom_range(0, 15)) : W'(256 - $urandom_range(1, 16));
               default: d = W'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 1)) apb_write(a, d, e);
            else                      apb_read(a, v, e);
         end
      end

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_timer_mc.md
Name: apb_timer_mc

Overview:
Parametrised multi-channel successor to the single 8-bit APB timer. It provides NUM_CH independent up/down counters of CNT_WIDTH bits behind one APB slave. Each channel adds auto-reload, a compare-match register, a maskable interrupt output and a readable live count. It sits on the peripheral APB bus next to the existing timer.

Parameters:
CNT_WIDTH, 8, counter/TDR/TCMP/TCNT width and APB data width; legal range 8..32.
NUM_CH, 2, number of timer channels; legal range 1..8.

Ports:
pclk  in  1  APB clock; the only clock.
preset  in  1  asynchronous, active-high reset.
psel  in  1  APB select.
penable  in  1  APB access phase.
pwrite  in  1  1 = write, 0 = read.
paddr  in  8  byte address.
pwdata  in  CNT_WIDTH  write data.
prdata  out  CNT_WIDTH  read data.
pready  out  1  tied 1; no wait states.
pslverr  out  1  error response on an illegal access.
irq  out  NUM_CH  per-channel interrupt, level-high.

Behaviour:
- Address map: channel c occupies c*8 .. c*8+4.
  - +0 TDR: reload value, R/W, CNT_WIDTH bits.
  - +1 TCR: control, R/W, 8 bits, zero-extended on read.
  - +2 TSR: status, R/W1C, 3 bits, zero-extended on read.
  - +3 TCMP: compare value, R/W.
  - +4 TCNT: live count, read-only.
- APB timing:
  - A write commits at the pclk edge where psel & penable & pwrite.
  - prdata is combinational from register state while psel & !pwrite; otherwise it is 0.
- Error response:
  - pslverr = 1 during the access phase for: offsets +5..+7, channel index >= NUM_CH, or any write to TCNT.
  - An errored write changes no state. An errored read returns 0.
- TCR bit fields:
  - [7] LOAD: while 1, CNT <= TDR every cycle and counting is held off.
  - [6] IE: interrupt enable.
  - [5] DOWN: 1 = count down.
  - [4] EN: count enable.
  - [3] ARL: auto-reload.
  - [2] reserved; reads as 0.
  - [1:0] CKS: tick = pclk/2, /4, /8, /16 for codes 00, 01, 10, 11.
- Prescaler:
  - One shared 4-bit free-running divider, cleared only by reset.
  - tick_N pulses for one pclk when divider[N-1:0] is all ones.
  - A CKS change takes effect at the next matching tick; there is no restart.
- Counting: on a selected tick with EN = 1 and LOAD = 0:
  - Up count: CNT+1. At the all-ones value the next value is ARL ? TDR : 0, and TSR[0] OVF is set.
  - Down count: CNT-1. At 0 the next value is ARL ? TDR : all-ones, and TSR[1] UDF is set.
- Compare:
  - TSR[2] CMF is set in the cycle the updated CNT value equals TCMP, on a counting tick only.
  - Loads never set CMF.
- Status clearing:
  - TSR flags are cleared by writing 1 to the corresponding bit; writing 0 has no effect.
  - If a hardware set and a software clear hit the same flag in the same cycle, the set wins.
- Interrupt: irq[c] = IE & |TSR[2:0], registered from TSR, so it asserts one cycle after the flag sets.
- Register update timing:
  - A TDR write while running does not affect CNT until LOAD or an auto-reload occurs.
  - A TCR write takes effect from the next cycle.
- Reset (any time, including mid-count): all TDR, TCR, TSR, TCMP, CNT = 0, the prescaler = 0 and all irq = 0. prdata = 0, pslverr = 0.
- Channels are fully independent apart from the shared prescaler.

Test Plan:
1. Reset: assert preset mid-count with ch0 running -> every register reads 0, irq = 0, and CNT stays 0 after release until re-enabled.
2. Load and count:
   - Stimulus: TDR0 = 0x13, TCR0 = 0x80, read TCNT0, then TCR0 = 0x10.
   - Response: TCNT0 = 0x13; it then increments by 1 every 2 pclk, reaching 0x15 after 4 pclk.
3. Overflow and W1C:
   - Stimulus: TDR0 = 0xFE, load, then TCR0 = 0x50 (IE | EN, /2).
   - Response: CNT = 0x00 after 2 ticks, TSR0 = 0x01, irq[0] = 1 one cycle later.
   - Then write TSR0 = 0x01 -> TSR0 = 0, irq[0] = 0.
4. Auto-reload down:
   - Stimulus: TDR1 = 0x03, load, then TCR1 = 0x3B (DOWN | EN | ARL, /16).
   - Response: sequence 3, 2, 1, 0, 3 with 16 pclk per step; UDF is set on the 0 -> 3 transition. ch0 is untouched.
5. Compare and collision:
   - Stimulus: TCMP0 = 0x05, up count from 0.
   - Response: CMF is set when CNT becomes 0x05.
   - Then issue a W1C write of 0x04 in the same cycle CMF re-sets -> CMF stays 1.
6. Errors:
   - Write 0xAA to 0x04 (TCNT0) -> pslverr = 1, TCNT unchanged.
   - Read 0x05 -> pslverr = 1, prdata = 0.
   - Write 0x10 with NUM_CH = 2 -> pslverr = 1, no state change.
   - Valid accesses -> pslverr = 0.
